vadd_cmd_sched: RTL

Command scheduler in front of the BRAM-backed vector-add compute engine.
- Queues host vector-add commands (operand/result base addresses, length, tag) in a small FIFO.
- Launches the engine one command at a time with a single-cycle start pulse, holds its operand inputs stable until done, and returns a tagged completion.
- Screens out commands the engine cannot execute safely (zero length, BRAM address overflow).

---
 rtl/vadd_sched_pkg.sv | 28 ++
 rtl/sched_cmd_fifo.sv | 63 ++++++
 rtl/vadd_cmd_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vadd_sched_pkg.sv
// Shared types for the vector-add command scheduler: FSM states, completion
// status codes and the default-width command record.
package vadd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    CPL    = 2'd3
  } sched_state_t;

  localparam logic [1:0] STS_OK    = 2'b00;
  localparam logic [1:0] STS_SKIP  = 2'b01;
  localparam logic [1:0] STS_RANGE = 2'b10;

  localparam int ADDR_W_DEF = 13;
  localparam int LEN_W_DEF  = 32;
  localparam int TAG_W_DEF  = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr_a;
    logic [ADDR_W_DEF-1:0] addr_b;
    logic [ADDR_W_DEF-1:0] addr_out;
    logic [LEN_W_DEF-1:0]  len;
    logic [TAG_W_DEF-1:0]  tag;
  } vadd_cmd_t;

endpackage

// File: rtl/sched_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO; the entry type is a parameter so the
// top can store commands sized to its own address/length/tag widths.
module sched_cmd_fifo
  import vadd_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = vadd_cmd_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A pop never frees room for a push in the same cycle when full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vadd_cmd_sched.sv
// Command scheduler in front of the vector-add engine: queues, screens and
// launches commands one at a time. SCHED_PERF_EN adds the cpl_cycles counter.
module vadd_cmd_sched
  import vadd_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 4,
  parameter int CYC_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr_b,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr_out,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic [TAG_WIDTH-1:0]     cmd_tag,
  output logic                     eng_start,
  output logic [ADDR_WIDTH-1:0]    eng_addr_a,
  output logic [ADDR_WIDTH-1:0]    eng_addr_b,
  output logic [ADDR_WIDTH-1:0]    eng_addr_out,
  output logic [LEN_WIDTH-1:0]     eng_len,
  input  logic                     eng_done,
  output logic                     cpl_valid,
  input  logic                     cpl_ready,
  output logic [TAG_WIDTH-1:0]     cpl_tag,
  output logic [1:0]               cpl_status,
`ifdef SCHED_PERF_EN
  output logic [CYC_WIDTH-1:0]     cpl_cycles,
`endif
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic [LEN_WIDTH-1:0]  len;
    logic [TAG_WIDTH-1:0]  tag;
  } cmd_t;

  localparam logic [LEN_WIDTH:0] LIMIT = {{LEN_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

  // Range check is done one bit wider than len so base+len cannot wrap.
  function automatic logic overflows(input logic [ADDR_WIDTH-1:0] base,
                                     input logic [LEN_WIDTH-1:0]  len);
    return ({1'b0, len} + (LEN_WIDTH+1)'(base)) > LIMIT;
  endfunction

  cmd_t          fifo_din, head;
  logic          fifo_full, fifo_empty, pop;
  sched_state_t  state_q, state_d;
  cmd_t          act_q, act_d;
  logic [1:0]    sts_q, sts_d;

  assign fifo_din = '{addr_a: cmd_addr_a, addr_b: cmd_addr_b, addr_out: cmd_addr_out,
                      len: cmd_len, tag: cmd_tag};

  sched_cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    sts_d   = sts_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          act_d = head;
          // len==0 must never reach the engine: its len-1 would wrap.
          if (head.len == '0) begin
            sts_d   = STS_SKIP;
            state_d = CPL;
          end else if (overflows(head.addr_a, head.len) ||
                       overflows(head.addr_b, head.len) ||
                       overflows(head.addr_out, head.len)) begin
            sts_d   = STS_RANGE;
            state_d = CPL;
          end else begin
            sts_d   = STS_OK;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH:  state_d = WAIT;
      WAIT:    if (eng_done) state_d = CPL;
      CPL:     if (cpl_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      sts_q   <= STS_OK;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      sts_q   <= sts_d;
    end
  end

`ifdef SCHED_PERF_EN
  logic [CYC_WIDTH-1:0] cyc_q, cyc_d;

  // The start cycle counts as 1; every WAIT cycle, including the done one, adds 1.
  always_comb begin
    cyc_d = cyc_q;
    case (state_q)
      IDLE:    if (pop) cyc_d = '0;
      LAUNCH:  cyc_d = CYC_WIDTH'(1);
      WAIT:    if (cyc_q != '1) cyc_d = cyc_q + CYC_WIDTH'(1);
      default: cyc_d = cyc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cpl_cycles = cyc_q;
`endif

  assign cmd_ready    = !fifo_full;
  assign eng_start    = (state_q == LAUNCH);
  assign eng_addr_a   = act_q.addr_a;
  assign eng_addr_b   = act_q.addr_b;
  assign eng_addr_out = act_q.addr_out;
  assign eng_len      = act_q.len;
  assign cpl_valid    = (state_q == CPL);
  assign cpl_tag      = act_q.tag;
  assign cpl_status   = sts_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule
